// File: rtl/cal_field_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cal_field_counter
//  Description : Generic calendar field counter (sec/min/hour/day/month/year).
//                Run mode counts on carry_in_i and wraps at the effective
//                maximum. Setup mode steps up or down on tick_i and wraps in
//                both directions. A runtime bound (max_dyn_i) clamps the
//                value. The block raises one-cycle carry_out_o and changed_o
//                pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module cal_field_counter #(
    parameter int WIDTH   = 7,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 99,
    parameter int RST_VAL = 25
) (
    input  logic             clk,
    input  logic             rst,          // synchronous, active-low
    input  logic             display_i,    // 0 = run, 1 = setup
    input  logic             setup_en_i,
    input  logic             inc_dec_i,    // 1 = +1, 0 = -1
    input  logic             tick_i,
    input  logic             carry_in_i,
    input  logic [WIDTH-1:0] max_dyn_i,
    output logic [WIDTH-1:0] value_o,
    output logic             carry_out_o,
    output logic             changed_o
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_SET  = 2'd1;
    localparam logic [1:0] ST_EXIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic             carry_out_q, carry_out_d;
    logic             changed_q, changed_d;

    logic [WIDTH-1:0] w_cap;
    logic [WIDTH-1:0] w_emax;
    logic             w_step;
    logic             w_run_inc;

    // Effective maximum: the runtime bound capped at MAX_VAL and floored at MIN_VAL
    always_comb begin
        w_cap  = (max_dyn_i > MAX_W) ? MAX_W : max_dyn_i;
        w_emax = (w_cap < MIN_W) ? MIN_W : w_cap;
    end

    // Mode state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode transitions: RUN -> SET on display, SET -> EXIT on release, EXIT lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  state_d = display_i ? ST_SET : ST_RUN;
            ST_SET:  state_d = display_i ? ST_SET : ST_EXIT;
            ST_EXIT: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Next value and pulse outputs; a setup step takes precedence, then a run increment, then clamping
    always_comb begin
        value_d     = value_q;
        snap_d      = snap_q;
        carry_out_d = 1'b0;
        changed_d   = 1'b0;
        w_step      = (state_q == ST_SET) && setup_en_i && tick_i;
        w_run_inc   = (state_q == ST_RUN) && carry_in_i;

        if (w_step) begin
            if (inc_dec_i) begin
                value_d = (value_q >= w_emax) ? MIN_W : value_q + ONE_W;
            end else begin
                value_d = (value_q <= MIN_W) ? w_emax : value_q - ONE_W;
            end
        end else if (w_run_inc) begin
            if (value_q >= w_emax) begin
                value_d     = MIN_W;
                carry_out_d = 1'b1;
            end else begin
                value_d = value_q + ONE_W;
            end
        end else if (value_q > w_emax) begin
            value_d = w_emax;
        end

        // Capture the value seen on the setup-entry edge for the later comparison
        if ((state_q == ST_RUN) && (state_d == ST_SET)) begin
            snap_d = value_q;
        end

        // changed_o is registered on the edge into EXIT so it is high during EXIT only
        if ((state_q == ST_SET) && (state_d == ST_EXIT)) begin
            changed_d = (value_d != snap_q);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q     <= RST_W;
            snap_q      <= RST_W;
            carry_out_q <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            value_q     <= value_d;
            snap_q      <= snap_d;
            carry_out_q <= carry_out_d;
            changed_q   <= changed_d;
        end
    end

    assign value_o     = value_q;
    assign carry_out_o = carry_out_q;
    assign changed_o   = changed_q;

endmodule
`default_nettype wire
